// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-channel stream mux with fixed or round-robin selection and a registered output stage
module stream_mux_rr #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [WIDTH-1:0] r_out_data;
    logic [SELW-1:0]  r_out_ch;
    logic             r_out_valid;
    logic [SELW-1:0]  r_last;

    logic             w_load;
    logic [N-1:0]     w_grant;
    logic [N-1:0]     w_ready;
    logic [SELW-1:0]  w_idx;
    logic             w_xfer;
    logic [WIDTH-1:0] w_sel_data;

    assign w_load = !r_out_valid | out_ready;

    // Fixed mode grants on select alone so in_ready stays independent of in_valid there.
    always_comb begin
        logic found;
        int   k;
        w_grant = '0;
        w_idx   = '0;
        found   = 1'b0;
        k       = 0;
        if (!mode) begin
            if (int'(sel) < N) begin
                w_idx        = sel;
                w_grant[sel] = w_load;
            end
        end else begin
            for (int i = 1; i <= N; i++) begin
                k = (int'(r_last) + i) % N;
                if (!found && in_valid[k]) begin
                    found      = 1'b1;
                    w_idx      = SELW'(k);
                    w_grant[k] = w_load;
                end
            end
        end
    end

    assign w_ready    = w_grant & {N{rst_n}};
    assign w_xfer     = |(w_ready & in_valid);
    assign w_sel_data = in_data[w_idx*WIDTH +: WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_last      <= SELW'(N - 1);
        end else if (w_xfer) begin
            r_out_data  <= w_sel_data;
            r_out_ch    <= w_idx;
            r_out_valid <= 1'b1;
            if (mode) begin
                r_last <= w_idx;
            end
        end else if (w_load) begin
            r_out_valid <= r_out_valid & !out_ready;
        end
    end

    assign in_ready  = w_ready;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;

endmodule
